// File: rtl/clock_mode_if.sv
// Key inputs and control outputs shared by the clock mode sequencer and its surroundings.
// master drives the keys and switch; slave is the sequencer.
interface clock_mode_if;
    logic       key_mode;
    logic       key_sel;
    logic       key_inc;
    logic       sw_start;
    logic [1:0] disp_sel;
    logic [1:0] edit_field;
    logic       inc_pulse;
    logic       time_load;
    logic       alarm_load;
    logic       blink;

    modport master (
        output key_mode, key_sel, key_inc, sw_start,
        input  disp_sel, edit_field, inc_pulse, time_load, alarm_load, blink
    );

    modport slave (
        input  key_mode, key_sel, key_inc, sw_start,
        output disp_sel, edit_field, inc_pulse, time_load, alarm_load, blink
    );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Digital clock mode sequencer: debounces the mode/sel/inc keys and the stopwatch
// switch, steps RUN/SET_TIME/SET_ALARM/STOPWATCH and drives display, edit and blink controls.
module clock_mode_ctrl #(
    parameter logic [19:0] DEBOUNCE_CYC = 20'd500000,
    parameter logic [23:0] BLINK_CYC    = 24'd6000000
) (
    input  logic            clk,
    input  logic            rst_n,
    clock_mode_if.slave     bus
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_TIME  = 2'd1,
        SET_ALARM = 2'd2,
        STOPWATCH = 2'd3
    } state_t;

    // Channel index: 0 mode, 1 sel, 2 inc, 3 stopwatch switch
    logic [3:0]  raw;
    logic [3:0]  sync1_q, sync2_q;
    logic [3:0]  acc_q, acc_d;
    logic [19:0] cnt_q [4];
    logic [19:0] cnt_d [4];
    logic [2:0]  ev_q, ev_d;

    state_t      state_q, state_d;
    logic [1:0]  disp_sel_q, disp_sel_d;
    logic [1:0]  edit_field_q, edit_field_d;
    logic        inc_pulse_q, inc_pulse_d;
    logic        time_load_q, time_load_d;
    logic        alarm_load_q, alarm_load_d;
    logic        blink_q, blink_d;
    logic [23:0] blink_cnt_q, blink_cnt_d;

    logic        sw_hold;
    logic        in_set_q;
    logic        in_set_d;
    logic        restart;

    assign raw      = {bus.sw_start, bus.key_inc, bus.key_sel, bus.key_mode};
    assign sw_hold  = acc_q[3];
    assign in_set_q = (state_q == SET_TIME) || (state_q == SET_ALARM);
    assign in_set_d = (state_d == SET_TIME) || (state_d == SET_ALARM);

    // The counter only runs while the synced level disagrees with the accepted one.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            acc_d[i] = acc_q[i];
            if (sync2_q[i] != acc_q[i]) begin
                if (cnt_q[i] == DEBOUNCE_CYC - 20'd1) begin
                    acc_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 20'd1;
                end
            end
        end
        ev_d = acc_d[2:0] & ~acc_q[2:0];
    end

    always_comb begin
        state_d      = state_q;
        edit_field_d = edit_field_q;
        inc_pulse_d  = 1'b0;
        time_load_d  = 1'b0;
        alarm_load_d = 1'b0;
        restart      = 1'b0;

        if (!sw_hold) begin
            if (ev_q[0]) begin
                case (state_q)
                    RUN: begin
                        state_d      = SET_TIME;
                        edit_field_d = 2'd3;
                    end
                    SET_TIME: begin
                        state_d      = SET_ALARM;
                        edit_field_d = 2'd3;
                        time_load_d  = 1'b1;
                    end
                    SET_ALARM: begin
                        state_d      = STOPWATCH;
                        edit_field_d = 2'd0;
                        alarm_load_d = 1'b1;
                    end
                    default: begin
                        state_d      = RUN;
                        edit_field_d = 2'd0;
                    end
                endcase
                restart = in_set_d;
            end else if (in_set_q && ev_q[1]) begin
                edit_field_d = (edit_field_q == 2'd1) ? 2'd3 : edit_field_q - 2'd1;
                restart      = 1'b1;
            end else if (in_set_q && ev_q[2]) begin
                inc_pulse_d = 1'b1;
                restart     = 1'b1;
            end
        end

        disp_sel_d = sw_hold ? 2'd3 : state_d;

        // Blink restarts visible whenever the user touches the edited field.
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        if (in_set_d) begin
            if (restart) begin
                blink_d = 1'b1;
            end else if (blink_cnt_q == BLINK_CYC - 24'd1) begin
                blink_d = ~blink_q;
            end else begin
                blink_d     = blink_q;
                blink_cnt_d = blink_cnt_q + 24'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            acc_q        <= '0;
            ev_q         <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            state_q      <= RUN;
            disp_sel_q   <= '0;
            edit_field_q <= '0;
            inc_pulse_q  <= 1'b0;
            time_load_q  <= 1'b0;
            alarm_load_q <= 1'b0;
            blink_q      <= 1'b0;
            blink_cnt_q  <= '0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            acc_q        <= acc_d;
            ev_q         <= ev_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            state_q      <= state_d;
            disp_sel_q   <= disp_sel_d;
            edit_field_q <= edit_field_d;
            inc_pulse_q  <= inc_pulse_d;
            time_load_q  <= time_load_d;
            alarm_load_q <= alarm_load_d;
            blink_q      <= blink_d;
            blink_cnt_q  <= blink_cnt_d;
        end
    end

    assign bus.disp_sel   = disp_sel_q;
    assign bus.edit_field = edit_field_q;
    assign bus.inc_pulse  = inc_pulse_q;
    assign bus.time_load  = time_load_q;
    assign bus.alarm_load = alarm_load_q;
    assign bus.blink      = blink_q;

endmodule
